// File: rtl/rca_pipe_nbit_pkg.sv
// Shared defaults and helpers for the pipelined ripple-carry adder/subtractor.
package rca_pipe_nbit_pkg;

  localparam int unsigned RCA_DEF_WIDTH = 32;
  localparam int unsigned RCA_DEF_CHUNK = 8;

  function automatic int unsigned rca_nstage(input int unsigned width, input int unsigned chunk);
    return width / chunk;
  endfunction

  function automatic bit rca_geom_ok(input int unsigned width, input int unsigned chunk);
    return (chunk != 0) && (width >= chunk) && ((width % chunk) == 0);
  endfunction

  // Full adder: returns {carry_out, sum}
  function automatic logic [1:0] rca_fa(input logic x, input logic y, input logic ci);
    return {(x & y) | (ci & (x ^ y)), x ^ y ^ ci};
  endfunction

endpackage

// File: rtl/rca_pipe_nbit_chunk.sv
// Combinational CHUNK-bit ripple adder built from a chain of full adders.
module rca_pipe_nbit_chunk
  import rca_pipe_nbit_pkg::*;
#(
  parameter int unsigned CHUNK = RCA_DEF_CHUNK
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             cin_i,
  output logic [CHUNK-1:0] sum_o,
  output logic             cout_o,
  output logic             cmsb_o
);

  logic [CHUNK:0] c;

  always_comb begin
    c     = '0;
    sum_o = '0;
    c[0]  = cin_i;
    for (int unsigned i = 0; i < CHUNK; i++) begin
      {c[i+1], sum_o[i]} = rca_fa(a_i[i], b_i[i], c[i]);
    end
  end

  assign cout_o = c[CHUNK];
  assign cmsb_o = c[CHUNK-1];

endmodule

// File: rtl/rca_pipe_nbit.sv
// Pipelined ripple-carry adder/subtractor: one CHUNK-bit slice per stage,
// valid/ready streaming with a combinational ready chain.
module rca_pipe_nbit
  import rca_pipe_nbit_pkg::*;
#(
  parameter int unsigned WIDTH = RCA_DEF_WIDTH,
  parameter int unsigned CHUNK = RCA_DEF_CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int unsigned     NSTAGE     = rca_nstage(WIDTH, CHUNK);
  localparam logic [WIDTH-1:0] SLICE_MASK = WIDTH'({CHUNK{1'b1}});

  if (!rca_geom_ok(WIDTH, CHUNK)) begin : g_bad_geom
    $error("rca_pipe_nbit: WIDTH (%0d) must be a nonzero multiple of CHUNK (%0d)", WIDTH, CHUNK);
  end

  logic [NSTAGE-1:0] v_q;
  logic [NSTAGE-1:0] v_d;
  logic [WIDTH-1:0]  a_q [NSTAGE];
  logic [WIDTH-1:0]  b_q [NSTAGE];
  logic [WIDTH-1:0]  s_q [NSTAGE];
  logic [WIDTH-1:0]  a_d [NSTAGE];
  logic [WIDTH-1:0]  b_d [NSTAGE];
  logic [WIDTH-1:0]  s_d [NSTAGE];
  logic [NSTAGE-1:0] c_q;
  logic [NSTAGE-1:0] c_d;
  logic              cmsb_w [NSTAGE];
  logic              ov_q;
  logic              ov_d;
  logic [NSTAGE:0]   rdy;

  // Each stage carries full-width operand and sum words; stage k only
  // consumes slice k of the operands and fills slice k of the sum.
  for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
    logic [WIDTH-1:0] a_src;
    logic [WIDTH-1:0] b_src;
    logic [WIDTH-1:0] s_src;
    logic             cin_src;
    logic [CHUNK-1:0] csum;

    if (k == 0) begin : g_head
      assign a_src   = a;
      assign b_src   = sub ? ~b : b;
      assign s_src   = '0;
      assign cin_src = sub | carry_in;
      assign v_d[k]  = in_valid;
    end else begin : g_tail
      assign a_src   = a_q[k-1];
      assign b_src   = b_q[k-1];
      assign s_src   = s_q[k-1];
      assign cin_src = c_q[k-1];
      assign v_d[k]  = v_q[k-1];
    end

    rca_pipe_nbit_chunk #(.CHUNK(CHUNK)) u_chunk (
      .a_i   (a_src[k*CHUNK +: CHUNK]),
      .b_i   (b_src[k*CHUNK +: CHUNK]),
      .cin_i (cin_src),
      .sum_o (csum),
      .cout_o(c_d[k]),
      .cmsb_o(cmsb_w[k])
    );

    assign a_d[k] = a_src;
    assign b_d[k] = b_src;
    assign s_d[k] = (s_src & ~(SLICE_MASK << (k*CHUNK))) | (WIDTH'(csum) << (k*CHUNK));
  end

  assign ov_d = c_d[NSTAGE-1] ^ cmsb_w[NSTAGE-1];

  // A stage may load when empty or when its successor is loading this cycle.
  always_comb begin
    rdy         = '0;
    rdy[NSTAGE] = out_ready;
    for (int unsigned i = 0; i < NSTAGE; i++) begin
      rdy[NSTAGE-1-i] = ~v_q[NSTAGE-1-i] | rdy[NSTAGE-i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_q  <= '0;
      c_q  <= '0;
      ov_q <= 1'b0;
      for (int unsigned i = 0; i < NSTAGE; i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
        s_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NSTAGE; i++) begin
        if (rdy[i]) begin
          v_q[i] <= v_d[i];
          a_q[i] <= a_d[i];
          b_q[i] <= b_d[i];
          s_q[i] <= s_d[i];
          c_q[i] <= c_d[i];
        end
      end
      if (rdy[NSTAGE-1]) begin
        ov_q <= ov_d;
      end
    end
  end

  assign in_ready  = rdy[0];
  assign out_valid = v_q[NSTAGE-1];
  assign sum       = s_q[NSTAGE-1];
  assign carry_out = c_q[NSTAGE-1];
  assign overflow  = ov_q;

endmodule

// File: tb/tb_rca_pipe_nbit.sv
// Scoreboard bench for rca_pipe_nbit: driver pushes expected results, monitor pops on output handshakes.
module tb_rca_pipe_nbit;

  typedef struct packed {
    logic        o;
    logic        c;
    logic [31:0] s;
  } exp_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        ci;
    logic        sb;
    logic        o;
    logic        c;
    logic [31:0] s;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid, in_ready, carry_in, sub;
  logic [31:0] a, b, sum;
  logic        out_valid, out_ready, carry_out, overflow;

  logic        iv8, ir8, ovl8, c8, o8;
  logic [7:0]  a8, b8, s8;
  logic        iv12, ir12, ovl12, c12, o12;
  logic [11:0] a12, b12, s12;

  int          errors, checks, accepted, cyc;
  exp_t        expq[$];
  int          pop_cyc[$];
  exp_t        mon_e;
  logic        hold;
  logic [33:0] held;
  logic        rand_en;
  logic        done5;
  vec_t        dv [10];

  rca_pipe_nbit #(.WIDTH(32), .CHUNK(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .carry_in(carry_in), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .carry_out(carry_out), .overflow(overflow)
  );

  rca_pipe_nbit #(.WIDTH(8), .CHUNK(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
    .a(a8), .b(b8), .carry_in(1'b0), .sub(1'b0),
    .out_valid(ovl8), .out_ready(1'b1),
    .sum(s8), .carry_out(c8), .overflow(o8)
  );

  rca_pipe_nbit #(.WIDTH(12), .CHUNK(4)) u_dut12 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv12), .in_ready(ir12),
    .a(a12), .b(b12), .carry_in(1'b0), .sub(1'b0),
    .out_valid(ovl12), .out_ready(1'b1),
    .sum(s12), .carry_out(c12), .overflow(o12)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  function automatic exp_t model(input logic [31:0] ta, input logic [31:0] tb,
                                 input logic tci, input logic tsb);
    exp_t        e;
    logic [31:0] bb;
    logic [32:0] r;
    bb  = tsb ? ~tb : tb;
    r   = {1'b0, ta} + {1'b0, bb} + {32'd0, (tsb ? 1'b1 : tci)};
    e.s = r[31:0];
    e.c = r[32];
    e.o = (ta[31] == bb[31]) && (r[31] != ta[31]);
    return e;
  endfunction

  task automatic send(input logic [31:0] ta, input logic [31:0] tb,
                      input logic tci, input logic tsb, input exp_t e);
    int unsigned waited;
    waited   = 0;
    a        = ta;
    b        = tb;
    carry_in = tci;
    sub      = tsb;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waited++;
      if (waited > 80) begin
        chk("send_timeout", 64'(in_ready), 64'd1);
        in_valid = 1'b0;
        return;
      end
      @(posedge clk);
    end
    @(posedge clk);
    expq.push_back(e);
    accepted++;
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (expq.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    chk("drain_empty", 64'(expq.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: scoreboard pop on output handshake, plus stall-hold stability.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold = 1'b0;
    end else begin
      if (hold) chk("stall_hold", 64'({out_valid, overflow, carry_out, sum}), 64'({1'b1, held}));
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_out: got sum=%h with no beat pending", sum);
        end else begin
          mon_e = expq.pop_front();
          chk("result", 64'({overflow, carry_out, sum}), 64'(mon_e));
          pop_cyc.push_back(cyc);
        end
      end
      hold = out_valid && !out_ready;
      held = {overflow, carry_out, sum};
    end
  end

  always @(posedge clk) begin
    if (rand_en) begin
      #1;
      out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    int lat;
    int base;
    int n;
    exp_t e1;
    errors = 0; checks = 0; accepted = 0; cyc = 0;
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; carry_in = 1'b0; sub = 1'b0;
    out_ready = 1'b1; rand_en = 1'b0; hold = 1'b0; held = '0; done5 = 1'b0;
    iv8 = 1'b0; a8 = '0; b8 = '0; iv12 = 1'b0; a12 = '0; b12 = '0;

    dv[0] = '{32'h00000005, 32'h00000007, 1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFFFFFE};
    dv[1] = '{32'h00000007, 32'h00000005, 1'b0, 1'b1, 1'b0, 1'b1, 32'h00000002};
    dv[2] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b1, 1'b0, 32'h80000000};
    dv[3] = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 1'b1, 1'b1, 32'h00000000};
    dv[4] = '{32'h000000FF, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00000100};
    dv[5] = '{32'h00000000, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0, 32'h00000001};
    dv[6] = '{32'h00000000, 32'h00000000, 1'b0, 1'b1, 1'b0, 1'b1, 32'h00000000};
    dv[7] = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 1'b1, 1'b1, 32'h7FFFFFFF};
    dv[8] = '{32'h12345678, 32'h0FEDCBA8, 1'b1, 1'b0, 1'b0, 1'b0, 32'h22222221};
    dv[9] = '{32'h00000010, 32'h00000001, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000000F};

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_outputs", 64'({out_valid, overflow, carry_out, sum}), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    // Wrap-around add with latency measurement
    e1 = '{o: 1'b0, c: 1'b1, s: 32'h00000000};
    send(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, e1);
    lat = 1;
    for (n = 0; n < 20; n++) begin
      @(negedge clk);
      if (out_valid) break;
      @(posedge clk);
      lat++;
    end
    chk("latency_w32", 64'(lat), 64'd4);
    drain();

    for (int i = 0; i < 10; i++) begin
      send(dv[i].a, dv[i].b, dv[i].ci, dv[i].sb, '{o: dv[i].o, c: dv[i].c, s: dv[i].s});
    end
    drain();

    // Back-to-back streaming at full rate
    base = pop_cyc.size();
    for (int i = 0; i < 10; i++) begin
      logic [31:0] ta, tb;
      ta = 32'h11111111 * 32'(i);
      tb = 32'h0F0F0F0F + 32'(i);
      send(ta, tb, 1'(i % 2), 1'(i == 3), model(ta, tb, 1'(i % 2), 1'(i == 3)));
    end
    drain();
    chk("b2b_count", 64'(pop_cyc.size() - base), 64'd10);
    if (pop_cyc.size() - base == 10)
      chk("b2b_span", 64'(pop_cyc[base+9] - pop_cyc[base]), 64'd9);

    // Output stalled while streaming 6 beats
    out_ready = 1'b0;
    base = accepted;
    done5 = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          logic [31:0] ta, tb;
          ta = 32'hA0000000 + 32'(i * 3);
          tb = 32'h5FFFFFFF - 32'(i);
          send(ta, tb, 1'b1, 1'b0, model(ta, tb, 1'b1, 1'b0));
        end
        done5 = 1'b1;
      end
    join_none
    repeat (12) @(posedge clk);
    @(negedge clk);
    chk("stall_accepted", 64'(accepted - base), 64'd4);
    chk("stall_in_ready", 64'(in_ready), 64'd0);
    chk("stall_out_valid", 64'(out_valid), 64'd1);
    @(posedge clk);
    #1 out_ready = 1'b1;
    for (n = 0; n < 300 && !done5; n++) @(posedge clk);
    chk("stall_done", 64'(done5), 64'd1);
    #1;
    drain();
    chk("stall_total", 64'(accepted - base), 64'd6);

    // Mid-flight reset with 3 beats in the pipe
    for (int i = 0; i < 3; i++) begin
      send(32'h01010101 * 32'(i + 1), 32'h00000042, 1'b0, 1'b0,
           model(32'h01010101 * 32'(i + 1), 32'h00000042, 1'b0, 1'b0));
    end
    rst_n = 1'b0;
    expq.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) n++;
    end
    chk("flush_no_stale", 64'(n), 64'd0);
    @(posedge clk);
    #1;

    // WIDTH=8 CHUNK=8: single registered adder
    a8 = 8'hFF; b8 = 8'h01; iv8 = 1'b1;
    @(negedge clk);
    chk("w8_in_ready", 64'(ir8), 64'd1);
    @(posedge clk);
    #1 iv8 = 1'b0;
    lat = 1;
    for (n = 0; n < 20; n++) begin
      @(negedge clk);
      if (ovl8) break;
      @(posedge clk);
      lat++;
    end
    chk("latency_w8", 64'(lat), 64'd1);
    chk("result_w8", 64'({o8, c8, s8}), 64'({1'b0, 1'b1, 8'h00}));
    @(posedge clk);
    #1;

    // WIDTH=12 CHUNK=4: three stages
    a12 = 12'hFFF; b12 = 12'h001; iv12 = 1'b1;
    @(negedge clk);
    chk("w12_in_ready", 64'(ir12), 64'd1);
    @(posedge clk);
    #1 iv12 = 1'b0;
    lat = 1;
    for (n = 0; n < 20; n++) begin
      @(negedge clk);
      if (ovl12) break;
      @(posedge clk);
      lat++;
    end
    chk("latency_w12", 64'(lat), 64'd3);
    chk("result_w12", 64'({o12, c12, s12}), 64'({1'b0, 1'b1, 12'h000}));
    @(posedge clk);
    #1;

    // Random operands with random gaps and random backpressure
    rand_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      logic [31:0] ta, tb;
      logic        tci, tsb;
      ta  = (i % 7 == 0) ? 32'hFFFFFFFF : $urandom;
      tb  = (i % 5 == 0) ? 32'h80000000 : $urandom;
      tci = 1'($urandom_range(0, 1));
      tsb = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      send(ta, tb, tci, tsb, model(ta, tb, tci, tsb));
    end
    rand_en = 1'b0;
    @(posedge clk);
    #2 out_ready = 1'b1;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
